alu_pipe: RTL

//  Parametrised, pipelined successor of the combinational RISC-V datapath ALU.

---
 rtl/alu_pipe.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Pipelined RISC-V datapath ALU with valid/ready handshakes on both sides; the result is formed in stage 0.
// Optional macro ALU_OVF_EN adds the ovf port (signed add/sub overflow, piped with the result).
module alu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int SHW    = 5
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [XLEN-1:0] PC,
  input  logic [19:0]     immediate,
  input  logic [2:0]      sel,
  input  logic [SHW-1:0]  shamt,
  input  logic            opcode2,
  input  logic            opcode5,
  input  logic            sub_add_n,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] outputs,
  output logic            zero
`ifdef ALU_OVF_EN
  ,
  output logic            ovf
`endif
);

  localparam int M = XLEN - 1;

  logic [XLEN-1:0] op_a, op_b, sum, lui, res;

  assign op_a = opcode2 ? PC : in1;
  assign op_b = opcode5 ? in2 : {{(XLEN-12){immediate[11]}}, immediate[11:0]};
  assign sum  = sub_add_n ? op_a - op_b : op_a + op_b;
  assign lui  = XLEN'($signed({immediate, 12'b0}));

`ifdef ALU_OVF_EN
  logic ovf_c;
  // Overflow only when the effective operand signs agree and the result sign flips.
  always_comb begin
    ovf_c = 1'b0;
    if (sel == 3'b000)
      ovf_c = ((op_a[M] ^ op_b[M]) == sub_add_n) && (sum[M] != op_a[M]);
  end
`endif

  always_comb begin
    res = '0;
    case (sel)
      3'b000: res = sum;
      3'b001: res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      3'b010: res = op_a ^ op_b;
      3'b011: res = op_a & op_b;
      3'b100: res = $signed(op_a) >>> shamt;
      3'b101: res = lui + (opcode2 ? PC : '0);
      3'b110: res = op_a[M] ? -op_a : op_a;
      3'b111: res = op_a | op_b;
    endcase
  end

  logic [STAGES-1:0] v, load;
  logic [XLEN-1:0]   d [STAGES];
`ifdef ALU_OVF_EN
  logic [STAGES-1:0] o;
`endif

  // A stage can take new data unless it and every stage after it are full while the sink stalls.
  for (genvar g = 0; g < STAGES; g++) begin : g_load
    assign load[g] = out_ready | ~(&v[STAGES-1:g]);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
`ifdef ALU_OVF_EN
      o <= '0;
`endif
    end else begin
      if (load[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d[0] <= res;
`ifdef ALU_OVF_EN
          o[0] <= ovf_c;
`endif
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
`ifdef ALU_OVF_EN
            o[i] <= o[i-1];
`endif
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[STAGES-1];
  assign outputs   = d[STAGES-1];
  assign zero      = v[STAGES-1] & ~(|d[STAGES-1]);
`ifdef ALU_OVF_EN
  assign ovf       = o[STAGES-1];
`endif

endmodule
